// File: rtl/framebuffer_ctrl.sv
// Double-buffered 3-bit palette framebuffer: clears the back buffer, accepts rasterizer writes, swaps on vblank.
// Latency: display read data is registered, one cycle after framebuffer_coords; accepted draws write in the accept cycle.
// Backpressure: draw_ready is low while clearing and while waiting for new_frame to swap; writes never stall reads.
// Coordinates are packed as {x[8:0], y[7:0]}: x in bits 16:8, y in bits 7:0.
module framebuffer_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [16:0] framebuffer_coords,
  output logic [2:0]  framebuffer_output,
  input  logic        new_frame,
  input  logic        draw_valid,
  output logic        draw_ready,
  input  logic [16:0] draw_coords,
  input  logic [2:0]  draw_color,
  input  logic        frame_done,
  output logic        frame_start
);

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              front_sel;
  logic              front_valid;
  logic [ADDR_W-1:0] clear_cnt;

  // buf0 is displayed when front_sel=0, buf1 when front_sel=1
  logic [2:0] buf0 [DEPTH];
  logic [2:0] buf1 [DEPTH];

  logic              back_we;
  logic [ADDR_W-1:0] back_addr;
  logic [2:0]        back_dat;

  function automatic logic in_range(input logic [16:0] c);
    return ({23'd0, c[16:8]} < 32'(WIDTH)) && ({24'd0, c[7:0]} < 32'(HEIGHT));
  endfunction

  // Only meaningful for in-range coordinates; the 320-wide case avoids a multiplier.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [16:0] c);
    logic [31:0] x;
    logic [31:0] y;
    x = {23'd0, c[16:8]};
    y = {24'd0, c[7:0]};
    if (WIDTH == 320)
      return ADDR_W'((y << 8) + (y << 6) + x);
    else
      return ADDR_W'(y * 32'(WIDTH) + x);
  endfunction

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next-state: clear runs to the last address, frame_done ends drawing, new_frame swaps
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:     if (clear_cnt == LAST_ADDR) state_nxt = DRAW;
      DRAW:      if (frame_done)             state_nxt = WAIT_SWAP;
      WAIT_SWAP: if (new_frame)              state_nxt = CLEAR;
      default:                               state_nxt = CLEAR;
    endcase
  end

  // Outputs: handshake and the single back-buffer write port (clear data or rasterizer pixel)
  always_comb begin
    draw_ready = 1'b0;
    back_we    = 1'b0;
    back_addr  = clear_cnt;
    back_dat   = 3'd0;
    case (state)
      CLEAR: back_we = !Reset;
      DRAW: begin
        draw_ready = 1'b1;
        // out-of-range pixels still handshake but are dropped here
        if (draw_valid && in_range(draw_coords)) begin
          back_we   = 1'b1;
          back_addr = lin_addr(draw_coords);
          back_dat  = draw_color;
        end
      end
      default: ;
    endcase
  end

  // Clear counter (saturating) and buffer swap on vblank
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      clear_cnt   <= '0;
    end else begin
      if (state == CLEAR && clear_cnt != LAST_ADDR)
        clear_cnt <= clear_cnt + 1'b1;
      if (state == WAIT_SWAP && new_frame) begin
        front_sel   <= ~front_sel;
        front_valid <= 1'b1;
        clear_cnt   <= '0;
      end
    end
  end

  // frame_start marks the cycle after the final clear write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) frame_start <= 1'b0;
    else       frame_start <= (state == CLEAR) && (clear_cnt == LAST_ADDR);
  end

  // Back-buffer write; memory contents are deliberately not reset
  always_ff @(posedge Clk) begin
    if (back_we) begin
      if (front_sel) buf0[back_addr] <= back_dat;
      else           buf1[back_addr] <= back_dat;
    end
  end

  // Registered display read from the front buffer, blanked when off-screen or before the first swap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      framebuffer_output <= 3'd0;
    else if (front_valid && in_range(framebuffer_coords))
      framebuffer_output <= front_sel ? buf1[lin_addr(framebuffer_coords)]
                                      : buf0[lin_addr(framebuffer_coords)];
    else
      framebuffer_output <= 3'd0;
  end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
`timescale 1ns/1ps
module tb_framebuffer_ctrl;

  localparam int W = 24;
  localparam int H = 10;
  localparam int N = W * H;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [16:0] framebuffer_coords = '0;
  logic [2:0]  framebuffer_output;
  logic        new_frame = 1'b0;
  logic        draw_valid = 1'b0;
  logic        draw_ready;
  logic [16:0] draw_coords = '0;
  logic [2:0]  draw_color = '0;
  logic        frame_done = 1'b0;
  logic        frame_start;

  always #5 Clk = ~Clk;

  framebuffer_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .framebuffer_coords(framebuffer_coords),
    .framebuffer_output(framebuffer_output),
    .new_frame(new_frame),
    .draw_valid(draw_valid),
    .draw_ready(draw_ready),
    .draw_coords(draw_coords),
    .draw_color(draw_color),
    .frame_done(frame_done),
    .frame_start(frame_start)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: two pixel arrays, which one is shown, and the frame phase.
  // Clearing is modelled as "N cycles pass, then the whole back buffer is zero".
  int m_mem [2][N];
  int m_phase;   // 0 clearing, 1 drawing, 2 waiting for swap
  int m_left;
  int m_fs;
  int m_fv;
  int e_out, e_ready, e_start;

  typedef struct { int x; int y; int exp; } rd_vec_t;
  rd_vec_t tab_a [8];
  rd_vec_t tab_b [4];

  function automatic logic [16:0] xy(input int x, input int y);
    return {9'(x), 8'(y)};
  endfunction

  function automatic bit m_inr(input logic [16:0] c);
    return (int'(c[16:8]) < W) && (int'(c[7:0]) < H);
  endfunction

  function automatic int m_lin(input logic [16:0] c);
    return int'(c[7:0]) * W + int'(c[16:8]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = N; m_fs = 0; m_fv = 0;
    e_out = 0; e_ready = 0; e_start = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    int nout;
    int nstart;
    nout = 0;
    nstart = 0;
    if (m_fv != 0 && m_inr(framebuffer_coords)) nout = m_mem[m_fs][m_lin(framebuffer_coords)];
    case (m_phase)
      0: begin
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < N; i++) m_mem[1 - m_fs][i] = 0;
          m_phase = 1;
          nstart = 1;
        end
      end
      1: begin
        if (draw_valid && m_inr(draw_coords)) m_mem[1 - m_fs][m_lin(draw_coords)] = int'(draw_color);
        if (frame_done) m_phase = 2;
      end
      default: begin
        if (new_frame) begin
          m_fs = 1 - m_fs; m_fv = 1; m_phase = 0; m_left = N;
        end
      end
    endcase
    e_out = nout;
    e_start = nstart;
    e_ready = (m_phase == 1) ? 1 : 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
    cyc++;
    check("model_out", 32'(framebuffer_output), e_out);
    check("model_ready", 32'(draw_ready), e_ready);
    check("model_start", 32'(frame_start), e_start);
  endtask

  task automatic idle();
    draw_valid = 1'b0; frame_done = 1'b0; new_frame = 1'b0;
  endtask

  task automatic draw(input int x, input int y, input int c);
    draw_valid = 1'b1; draw_coords = xy(x, y); draw_color = 3'(c);
    tick();
    idle();
  endtask

  task automatic wait_start(input string name, input int from_cyc, input int exp_len);
    int seen;
    seen = -1;
    for (int i = 0; i < 2 * N && seen < 0; i++) begin
      tick();
      if (frame_start === 1'b1) seen = cyc;
    end
    check(name, 32'(seen - from_cyc), 32'(exp_len));
  endtask

  task automatic read_table(input int which);
    int cnt;
    cnt = (which == 0) ? 8 : 4;
    for (int i = 0; i < cnt; i++) begin
      rd_vec_t v;
      v = (which == 0) ? tab_a[i] : tab_b[i];
      framebuffer_coords = xy(v.x, v.y);
      tick();
      check((which == 0) ? "tab_a_read" : "tab_b_read", 32'(framebuffer_output), 32'(v.exp));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rel;
    int swap;
    // front buffer after the first swap: (10,5)=3, (0,0)=5, out-of-range draws dropped
    tab_a[0] = '{10, 5, 3};
    tab_a[1] = '{11, 5, 0};
    tab_a[2] = '{0, 0, 5};
    tab_a[3] = '{0, 1, 0};        // alias of (W,0) if the range check were missing
    tab_a[4] = '{W, 0, 0};
    tab_a[5] = '{0, H, 0};
    tab_a[6] = '{9, 5, 0};
    tab_a[7] = '{W - 1, H - 1, 0};
    // front buffer after the second swap: freshly cleared, then (1,1)=6
    tab_b[0] = '{1, 1, 6};
    tab_b[1] = '{10, 5, 0};
    tab_b[2] = '{0, 0, 0};
    tab_b[3] = '{2, 1, 0};

    model_reset();
    Reset = 1'b1;
    #2;
    check("rst_out", 32'(framebuffer_output), 0);
    check("rst_ready", 32'(draw_ready), 0);
    check("rst_start", 32'(frame_start), 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    rel = cyc;
    wait_start("clear_len_reset", rel, N);
    tick();
    check("start_width", 32'(frame_start), 0);
    check("ready_in_draw", 32'(draw_ready), 1);

    // out-of-range draws, a real pixel, then a draw coinciding with frame_done
    draw(W, 0, 7);
    draw(0, H, 7);
    draw(10, 5, 3);
    tick();
    draw_valid = 1'b1; draw_coords = xy(0, 0); draw_color = 3'd5; frame_done = 1'b1;
    tick();
    idle();
    check("ready_after_done", 32'(draw_ready), 0);
    tick(); tick();
    new_frame = 1'b1;
    tick();
    swap = cyc;
    idle();
    read_table(0);
    // new_frame / frame_done during clear are ignored
    new_frame = 1'b1; frame_done = 1'b1;
    tick();
    idle();
    wait_start("clear_len_swap", swap, N);

    // new_frame during draw: no swap, old frame keeps displaying
    new_frame = 1'b1;
    tick();
    idle();
    read_table(0);
    draw(1, 1, 6);
    frame_done = 1'b1; new_frame = 1'b1;
    tick();
    idle();
    check("ready_wait_swap", 32'(draw_ready), 0);
    read_table(0);
    new_frame = 1'b1;
    tick();
    idle();
    read_table(1);

    // reset halfway through the clear
    framebuffer_coords = xy(1, 1);
    for (int i = 0; i < N / 2; i++) tick();
    check("pre_reset_out", 32'(framebuffer_output), 6);
    Reset = 1'b1;
    #1;
    check("mid_rst_out", 32'(framebuffer_output), 0);
    check("mid_rst_ready", 32'(draw_ready), 0);
    model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    rel = cyc;
    wait_start("clear_len_rerun", rel, N);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      framebuffer_coords = xy(int'($urandom_range(W + 3)), int'($urandom_range(H + 3)));
      draw_valid  = 1'($urandom_range(1));
      draw_coords = xy(int'($urandom_range(W + 3)), int'($urandom_range(H + 3)));
      draw_color  = 3'($urandom_range(7));
      frame_done  = ($urandom_range(99) < 4);
      new_frame   = ($urandom_range(99) < 6);
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_ctrl.md
FRAMEBUFFER_CTRL -- requirements
Module: framebuffer_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, default 320, pixels per line; HEIGHT, default 240, lines per frame.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port framebuffer_coords  input  screenXY (x 9b, y 8b)  display read address.
REQ-005 SHALL have port framebuffer_output  output  3  palette index at framebuffer_coords.
REQ-006 SHALL have port new_frame  input  1  one-cycle pulse per frame from the display stage, asserted during vertical blanking.
REQ-007 SHALL have port draw_valid  input  1  rasterizer pixel-write request.
REQ-008 SHALL have port draw_ready  output  1  write accepted when draw_valid and draw_ready are both high.
REQ-009 SHALL have port draw_coords  input  screenXY  write address.
REQ-010 SHALL have port draw_color  input  3  palette index to write.
REQ-011 SHALL have port frame_done  input  1  pulse: rasterizer finished back buffer.
REQ-012 SHALL have port frame_start  output  1  pulse: back buffer cleared, rasterizing may begin.

Function
REQ-013 SHALL hold two internal WIDTH*HEIGHT x 3b buffers; front_sel (1b) selects the display buffer, and the other buffer is the back buffer.
REQ-014 SHALL compute linear address = y*WIDTH + x as 17b, using shift-add (y<<8)+(y<<6)+x for the default parameters.
REQ-015 SHALL present framebuffer_output registered, one cycle after framebuffer_coords, read from the front buffer.
REQ-016 SHALL output 0 for reads with x>=WIDTH or y>=HEIGHT, and whenever front_valid=0.
REQ-017 SHALL implement FSM states CLEAR, DRAW, WAIT_SWAP.
REQ-018 CLEAR: write 0 to back buffer, one address per cycle, from 0 to WIDTH*HEIGHT-1 (76800 cycles); draw_ready=0.
REQ-019 CLEAR -> DRAW after the final address is written; frame_start SHALL pulse high exactly one cycle on that transition.
REQ-020 DRAW: draw_ready=1; each accepted write stores draw_color to the back buffer in the acceptance cycle.
REQ-021 Accepted writes with x>=WIDTH or y>=HEIGHT SHALL complete the handshake and be discarded with no memory write.
REQ-022 DRAW -> WAIT_SWAP on frame_done; a draw_valid in the same cycle SHALL still be accepted and written.
REQ-023 WAIT_SWAP: draw_ready=0; new_frame SHALL toggle front_sel, set front_valid=1, reset the clear counter, and enter CLEAR next cycle.
REQ-024 new_frame in CLEAR or DRAW SHALL be ignored (previous front buffer keeps displaying; no tearing).
REQ-025 frame_done outside DRAW SHALL be ignored; frame_done and new_frame in the same DRAW cycle SHALL only enter WAIT_SWAP, with the swap on a later new_frame.
REQ-026 Clear counter SHALL saturate, never wrap, and never write past WIDTH*HEIGHT-1.
REQ-027 Display reads and back-buffer writes SHALL occur in the same cycle without stalls (separate buffers).

Reset
REQ-028 On Reset high, outputs SHALL be asynchronously forced to: framebuffer_output=0, draw_ready=0, frame_start=0.
REQ-029 On Reset high, state SHALL be asynchronously forced to: FSM=CLEAR, front_sel=0, front_valid=0, clear counter=0.
REQ-030 Reset mid-DRAW or mid-CLEAR SHALL abandon the operation; memory contents are not reset; after release a full clear of buffer 1 restarts.
REQ-031 The first cycle after Reset deasserts SHALL perform the clear write to address 0.

Verification
REQ-032 Reset release, no draws -> frame_start pulses once exactly 76800 cycles later; framebuffer_output=0 throughout.
REQ-033 In DRAW, write (10,5)=3, frame_done, then new_frame -> read (10,5) returns 3 one cycle later; (11,5) returns 0; frame_start pulses 76800 cycles after swap.
REQ-034 draw_valid held with (320,0)=7 then (0,240)=7 -> both accepted; all subsequent front reads are 0.
REQ-035 new_frame during DRAW with prior frame F shown -> front_sel unchanged; reads still return F contents.
REQ-036 frame_done and draw_valid same cycle with (0,0)=5 -> pixel written; draw_ready=0 next cycle; after new_frame, read (0,0)=5.
REQ-037 Reset asserted halfway through CLEAR -> draw_ready=0 and framebuffer_output=0 immediately; full 76800-cycle clear repeats after release.
